// File: rtl/bpu_pkg.sv
// Shared types for the local branch predictor: 2-bit counter encodings,
// control FSM states and small elaboration helpers.
package bpu_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic ctr_t sat_ctr_next(input ctr_t ctr, input logic taken);
        if (taken) begin
            return (ctr == ST) ? ST : ctr_t'(ctr + 2'd1);
        end
        return (ctr == SNT) ? SNT : ctr_t'(ctr - 2'd1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bpu_btb.sv
// Direct-mapped branch target buffer with a registered read port, one write
// port and a per-entry valid clear driven by the init sweep.
module bpu_btb #(
    parameter  int XLEN     = 32,
    parameter  int ENTRIES  = 64,
    parameter  int TAG_BITS = 12,
    localparam int IDX      = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_en,
    input  logic [XLEN-1:0] rd_pc,
    output logic            rd_hit,
    output logic            rd_cond,
    output logic [XLEN-1:0] rd_target,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_pc,
    input  logic            wr_cond,
    input  logic [XLEN-1:0] wr_target,
    input  logic            clr_en,
    input  logic [IDX-1:0]  clr_idx
);

    localparam int TAG_MSB = IDX + TAG_BITS + 1;

    typedef struct packed {
        logic                valid;
        logic                cond;
        logic [TAG_BITS-1:0] tag;
        logic [XLEN-1:0]     target;
    } entry_t;

    entry_t              mem [ENTRIES];
    entry_t              rd_ent;
    logic [IDX-1:0]      rd_idx;
    logic [IDX-1:0]      wr_idx;
    logic [TAG_BITS-1:0] rd_tag;
    logic [TAG_BITS-1:0] wr_tag;
    logic                hit;
    logic                unused_pc_bits;

    assign rd_idx = rd_pc[IDX+1:2];
    assign wr_idx = wr_pc[IDX+1:2];
    assign rd_tag = rd_pc[TAG_MSB:IDX+2];
    assign wr_tag = wr_pc[TAG_MSB:IDX+2];
    assign rd_ent = mem[rd_idx];
    assign hit    = rd_ent.valid && (rd_ent.tag == rd_tag);

    assign unused_pc_bits = ^{rd_pc[1:0], wr_pc[1:0], rd_pc[XLEN-1:TAG_MSB+1], wr_pc[XLEN-1:TAG_MSB+1]};

    // Storage is never reset; the init sweep clears valid bits one entry per cycle.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_idx].valid <= 1'b0;
        end else if (wr_en) begin
            mem[wr_idx] <= '{valid: 1'b1, cond: wr_cond, tag: wr_tag, target: wr_target};
        end
    end

    // Read registers sample the old contents when a write hits the same entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_hit    <= 1'b0;
            rd_cond   <= 1'b0;
            rd_target <= '0;
        end else if (rd_en) begin
            rd_hit    <= hit;
            rd_cond   <= rd_ent.cond;
            rd_target <= hit ? rd_ent.target : '0;
        end
    end

endmodule

// File: rtl/bpu_local_predictor.sv
// Fetch-side predictor: BTB plus two-level local predictor (LHT -> PHT of
// 2-bit counters), with a self-clearing init sweep after reset.
module bpu_local_predictor
    import bpu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 64,
    parameter int TAG_BITS    = 12,
    parameter int LHT_ENTRIES = 32,
    parameter int HIST_BITS   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 init_done_o,
    input  logic                 lkp_valid_i,
    input  logic [XLEN-1:0]      lkp_pc_i,
    output logic                 pred_valid_o,
    output logic                 pred_hit_o,
    output logic                 pred_taken_o,
    output logic [XLEN-1:0]      pred_target_o,
    output logic [HIST_BITS-1:0] pred_hist_o,
    input  logic                 upd_valid_i,
    input  logic [XLEN-1:0]      upd_pc_i,
    input  logic                 upd_cond_i,
    input  logic                 upd_taken_i,
    input  logic [XLEN-1:0]      upd_target_i,
    input  logic [HIST_BITS-1:0] upd_hist_i
);

    localparam int BTB_IDX     = $clog2(BTB_ENTRIES);
    localparam int LHT_IDX     = $clog2(LHT_ENTRIES);
    localparam int PHT_ENTRIES = 1 << HIST_BITS;
    localparam int SWEEP_DEPTH = max3(BTB_ENTRIES, LHT_ENTRIES, PHT_ENTRIES);
    localparam int SW          = (SWEEP_DEPTH > 1) ? $clog2(SWEEP_DEPTH) : 1;

    state_t               state;
    logic [SW-1:0]        sweep_ctr;
    logic                 running;
    logic                 lkp_accept;
    logic                 upd_fire;
    logic                 upd_dir;
    logic                 btb_clr;
    logic                 btb_cond;
    logic                 pht_msb;
    logic                 lkp_pht_msb;
    logic [LHT_IDX-1:0]   lkp_lidx;
    logic [LHT_IDX-1:0]   upd_lidx;
    logic [HIST_BITS-1:0] lkp_hist;
    logic [HIST_BITS-1:0] hist_next;
    logic [HIST_BITS-1:0] lht [LHT_ENTRIES];
    ctr_t                 pht [PHT_ENTRIES];

    assign running     = (state == RUN);
    assign lkp_accept  = running && lkp_valid_i;
    assign upd_fire    = running && upd_valid_i;
    assign upd_dir     = !upd_cond_i || upd_taken_i;
    assign lkp_lidx    = lkp_pc_i[LHT_IDX+1:2];
    assign upd_lidx    = upd_pc_i[LHT_IDX+1:2];
    assign lkp_hist    = lht[lkp_lidx];
    assign lkp_pht_msb = pht[lkp_hist][1];
    // Cast keeps the low HIST_BITS, so a 1-bit history degenerates to just the outcome.
    assign hist_next   = HIST_BITS'({upd_hist_i, upd_taken_i});
    assign btb_clr     = !running && (32'(sweep_ctr) < 32'(BTB_ENTRIES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= INIT;
            sweep_ctr   <= '0;
            init_done_o <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (32'(sweep_ctr) == 32'(SWEEP_DEPTH - 1)) begin
                        state       <= RUN;
                        init_done_o <= 1'b1;
                        sweep_ctr   <= '0;
                    end else begin
                        sweep_ctr <= sweep_ctr + SW'(1);
                    end
                end
                RUN: state <= RUN;
                default: state <= INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!running) begin
            if (32'(sweep_ctr) < 32'(LHT_ENTRIES)) lht[sweep_ctr[LHT_IDX-1:0]] <= '0;
            if (32'(sweep_ctr) < 32'(PHT_ENTRIES)) pht[sweep_ctr[HIST_BITS-1:0]] <= WNT;
        end else if (upd_fire && upd_cond_i) begin
            pht[upd_hist_i] <= sat_ctr_next(pht[upd_hist_i], upd_taken_i);
            lht[upd_lidx]   <= hist_next;
        end
    end

    // Prediction stage: direction bit and history snapshot registered alongside the BTB read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid_o <= 1'b0;
            pred_hist_o  <= '0;
            pht_msb      <= 1'b0;
        end else begin
            pred_valid_o <= lkp_accept;
            if (lkp_accept) begin
                pred_hist_o <= lkp_hist;
                pht_msb     <= lkp_pht_msb;
            end
        end
    end

    assign pred_taken_o = pred_hit_o && (!btb_cond || pht_msb);

    bpu_btb #(
        .XLEN     (XLEN),
        .ENTRIES  (BTB_ENTRIES),
        .TAG_BITS (TAG_BITS)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_en     (lkp_accept),
        .rd_pc     (lkp_pc_i),
        .rd_hit    (pred_hit_o),
        .rd_cond   (btb_cond),
        .rd_target (pred_target_o),
        .wr_en     (upd_fire && upd_dir),
        .wr_pc     (upd_pc_i),
        .wr_cond   (upd_cond_i),
        .wr_target (upd_target_i),
        .clr_en    (btb_clr),
        .clr_idx   (sweep_ctr[BTB_IDX-1:0])
    );

endmodule

// File: tb/tb_bpu_local_predictor.sv
// Directed bench for bpu_local_predictor with a scoreboard of expected predictions.
module tb_bpu_local_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done_o;
    logic        lkp_valid_i;
    logic [31:0] lkp_pc_i;
    logic        pred_valid_o;
    logic        pred_hit_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic [3:0]  pred_hist_o;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_cond_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic [3:0]  upd_hist_i;

    typedef struct packed {
        logic        hit;
        logic        taken;
        logic [31:0] target;
        logic [3:0]  hist;
    } exp_t;

    exp_t  sb [$];
    string sb_tag [$];
    int    n_tests = 0;
    int    n_fail  = 0;

    always #5 clk = ~clk;

    bpu_local_predictor #(
        .XLEN        (32),
        .BTB_ENTRIES (64),
        .TAG_BITS    (12),
        .LHT_ENTRIES (32),
        .HIST_BITS   (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .init_done_o   (init_done_o),
        .lkp_valid_i   (lkp_valid_i),
        .lkp_pc_i      (lkp_pc_i),
        .pred_valid_o  (pred_valid_o),
        .pred_hit_o    (pred_hit_o),
        .pred_taken_o  (pred_taken_o),
        .pred_target_o (pred_target_o),
        .pred_hist_o   (pred_hist_o),
        .upd_valid_i   (upd_valid_i),
        .upd_pc_i      (upd_pc_i),
        .upd_cond_i    (upd_cond_i),
        .upd_taken_i   (upd_taken_i),
        .upd_target_i  (upd_target_i),
        .upd_hist_i    (upd_hist_i)
    );

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Advance one clock, then compare any prediction the scoreboard expects.
    task automatic step();
        exp_t  e;
        string t;
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            t = sb_tag.pop_front();
            check({t, "_valid"},  32'(pred_valid_o), 32'd1);
            check({t, "_hit"},    32'(pred_hit_o),   32'(e.hit));
            check({t, "_taken"},  32'(pred_taken_o), 32'(e.taken));
            check({t, "_target"}, pred_target_o,     e.target);
            check({t, "_hist"},   32'(pred_hist_o),  32'(e.hist));
        end
    endtask

    task automatic drive_upd(input logic [31:0] pc, input logic cond, input logic taken,
                             input logic [31:0] tgt, input logic [3:0] hist);
        upd_valid_i  = 1'b1;
        upd_pc_i     = pc;
        upd_cond_i   = cond;
        upd_taken_i  = taken;
        upd_target_i = tgt;
        upd_hist_i   = hist;
    endtask

    task automatic drive_lkp(input logic [31:0] pc, input logic hit, input logic taken,
                             input logic [31:0] tgt, input logic [3:0] hist, input string name);
        lkp_valid_i = 1'b1;
        lkp_pc_i    = pc;
        sb.push_back('{hit: hit, taken: taken, target: tgt, hist: hist});
        sb_tag.push_back(name);
    endtask

    task automatic update(input logic [31:0] pc, input logic cond, input logic taken,
                          input logic [31:0] tgt, input logic [3:0] hist);
        drive_upd(pc, cond, taken, tgt, hist);
        step();
        upd_valid_i = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic hit, input logic taken,
                          input logic [31:0] tgt, input logic [3:0] hist, input string name);
        drive_lkp(pc, hit, taken, tgt, hist, name);
        step();
        lkp_valid_i = 1'b0;
    endtask

    task automatic wait_init(input string name);
        int   k;
        logic saw;
        k   = 0;
        saw = 1'b0;
        while (init_done_o !== 1'b1 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
            if (pred_valid_o !== 1'b0) saw = 1'b1;
        end
        check({name, "_cycles"}, 32'(k), 32'd64);
        check({name, "_no_pred"}, 32'(saw), 32'd0);
    endtask

    initial begin
        rst          = 1'b1;
        lkp_valid_i  = 1'b0;
        lkp_pc_i     = '0;
        upd_valid_i  = 1'b0;
        upd_pc_i     = '0;
        upd_cond_i   = 1'b0;
        upd_taken_i  = 1'b0;
        upd_target_i = '0;
        upd_hist_i   = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_init_done", 32'(init_done_o),  32'd0);
        check("rst_valid",     32'(pred_valid_o), 32'd0);
        check("rst_hit",       32'(pred_hit_o),   32'd0);
        check("rst_taken",     32'(pred_taken_o), 32'd0);
        check("rst_target",    pred_target_o,     32'd0);
        check("rst_hist",      32'(pred_hist_o),  32'd0);

        // Lookups and an update held through the sweep must all be dropped.
        @(negedge clk);
        rst         = 1'b0;
        lkp_valid_i = 1'b1;
        lkp_pc_i    = 32'h100;
        drive_upd(32'h104, 1'b0, 1'b0, 32'h44, 4'h0);
        wait_init("init");
        lkp_valid_i = 1'b0;
        upd_valid_i = 1'b0;

        lookup(32'h100, 1'b0, 1'b0, 32'h0, 4'h0, "cold_100");
        lookup(32'h104, 1'b0, 1'b0, 32'h0, 4'h0, "init_upd_dropped");

        // Training on pc 0x100 (BTB idx 0, LHT idx 0).
        update(32'h100, 1'b1, 1'b1, 32'h80, 4'h0);          // PHT0 10, LHT 0001
        lookup(32'h100, 1'b1, 1'b0, 32'h80, 4'h1, "train1"); // PHT1 still 01
        update(32'h100, 1'b1, 1'b1, 32'h80, 4'h0);          // PHT0 11
        update(32'h100, 1'b1, 1'b1, 32'h80, 4'h0);          // PHT0 stays 11
        update(32'h100, 1'b1, 1'b1, 32'h80, 4'h1);          // PHT1 10, LHT 0011
        lookup(32'h100, 1'b1, 1'b0, 32'h80, 4'h3, "train_hist3");
        update(32'h100, 1'b1, 1'b0, 32'h80, 4'h0);          // PHT0 10, LHT 0000
        lookup(32'h100, 1'b1, 1'b1, 32'h80, 4'h0, "sat_high");

        repeat (4) update(32'h100, 1'b1, 1'b0, 32'h80, 4'h0); // PHT0 01,00,00,00
        update(32'h100, 1'b1, 1'b1, 32'h80, 4'h0);          // PHT0 01, LHT 0001
        update(32'h100, 1'b1, 1'b1, 32'h80, 4'h0);          // PHT0 10
        lookup(32'h100, 1'b1, 1'b1, 32'h80, 4'h1, "pht1_taken");
        update(32'h100, 1'b1, 1'b0, 32'h80, 4'h0);          // PHT0 01, LHT 0000
        lookup(32'h100, 1'b1, 1'b0, 32'h80, 4'h0, "sat_low");

        // 0x200 shares BTB/LHT index 0 with 0x100 but has a different tag.
        lookup(32'h200, 1'b0, 1'b0, 32'h0, 4'h0, "alias_miss");
        update(32'h200, 1'b0, 1'b0, 32'h40, 4'h5);
        lookup(32'h200, 1'b1, 1'b1, 32'h40, 4'h0, "uncond");
        lookup(32'h100, 1'b0, 1'b0, 32'h0, 4'h0, "alias_evicted");

        // Same-cycle lookup and update: read-before-write.
        drive_upd(32'h300, 1'b0, 1'b0, 32'h60, 4'h0);
        drive_lkp(32'h300, 1'b0, 1'b0, 32'h0, 4'h0, "collide_same");
        step();
        upd_valid_i = 1'b0;
        lkp_valid_i = 1'b0;
        lookup(32'h300, 1'b1, 1'b1, 32'h60, 4'h0, "collide_next");

        step();
        check("hold_valid",  32'(pred_valid_o), 32'd0);
        check("hold_hit",    32'(pred_hit_o),   32'd1);
        check("hold_target", pred_target_o,     32'h60);

        // Reset mid-run clears outputs immediately and restarts the sweep.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_init_done", 32'(init_done_o),  32'd0);
        check("mid_rst_hit",       32'(pred_hit_o),   32'd0);
        check("mid_rst_taken",     32'(pred_taken_o), 32'd0);
        check("mid_rst_target",    pred_target_o,     32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_init("reinit");

        lookup(32'h300, 1'b0, 1'b0, 32'h0, 4'h0, "post_rst_300");
        lookup(32'h100, 1'b0, 1'b0, 32'h0, 4'h0, "post_rst_100");
        update(32'h100, 1'b1, 1'b1, 32'h80, 4'h0);          // PHT0 10, LHT 0001
        lookup(32'h100, 1'b1, 1'b0, 32'h80, 4'h1, "post_rst_pht1");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
